// File: rtl/rr_arbiter8_pkg.sv
// rr_arbiter8_pkg: shared state encodings, request count and one-hot decode helper
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    function automatic logic [2:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < N_REQ; i++)
            if (oh[i]) idx = 3'(i);
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational round-robin pick, first set req bit at or after ptr
module rr_pick8
    import rr_arbiter8_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       ptr,
    output logic [N_REQ-1:0] pick
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   first;
    logic [2*N_REQ-1:0] back;

    // rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_REQ-1:0];
        first = rot & (~rot + 1'b1);
        back  = {first, first} << ptr;
        pick  = back[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: registered round-robin arbiter with ack-hold; optional forced release under ARB_TIMEOUT_EN
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int RESET_PTR      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             grant_ack,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic             timeout
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end
    if (RESET_PTR < 0 || RESET_PTR > 7) begin : g_bad_ptr
        $error("RESET_PTR out of range");
    end

    state_t           state, state_n;
    logic [2:0]       ptr, ptr_n;
    logic [N_REQ-1:0] grant_n, pick;
    logic             timeout_n, expire;

    rr_pick8 u_pick (.req(req), .ptr(ptr), .pick(pick));

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt, cnt_n;

    assign expire = (state == ST_GRANT) && !grant_ack && (cnt == 8'(TIMEOUT_CYCLES - 1));

    // age counter: zero on entry to GRANT, counts each un-acked GRANT cycle
    always_comb cnt_n = (state == ST_GRANT) ? cnt + 8'd1 : 8'd0;

    // age counter register
    always_ff @(posedge clk)
        cnt <= rst ? 8'd0 : cnt_n;
`else
    assign expire = 1'b0;
`endif

    // next-state: IDLE loads a pick, GRANT holds until ack or expiry
    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        grant_n   = grant;
        timeout_n = 1'b0;
        if (state == ST_IDLE) begin
            if (|req) begin
                grant_n = pick;
                state_n = ST_GRANT;
            end
        end else if (grant_ack || expire) begin
            grant_n   = '0;
            state_n   = ST_IDLE;
            ptr_n     = onehot_to_idx(grant) + 3'd1;
            timeout_n = expire;
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= 3'(RESET_PTR);
            grant       <= '0;
            grant_valid <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            ptr         <= ptr_n;
            grant       <= grant_n;
            grant_valid <= |grant_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed self-checking bench for rr_arbiter8 (ARB_TIMEOUT_EN selects timeout tests)
module tb_rr_arbiter8;

    logic       clk, rst, grant_ack, grant_valid, timeout;
    logic [7:0] req, grant;
    int         vectors, miscompares;

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD = 3;
`else
    localparam int HOLD = 5;
`endif

    rr_arbiter8 #(.TIMEOUT_CYCLES(4), .RESET_PTR(0)) dut (
        .clk(clk), .rst(rst), .req(req), .grant_ack(grant_ack),
        .grant(grant), .grant_valid(grant_valid), .timeout(timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 8'hFF; grant_ack = 1'b0;
        tick; tick;
        vectors++;
        if ({grant, grant_valid, timeout} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL reset: got grant=%h valid=%b to=%b want 00 0 0", grant, grant_valid, timeout);
        end
        rst = 1'b0;
        tick;
        vectors++;
        if ({grant, grant_valid, timeout} !== {8'h01, 2'b10}) begin
            miscompares++;
            $display("FAIL first_grant: got grant=%h valid=%b to=%b want 01 1 0", grant, grant_valid, timeout);
        end
        grant_ack = 1'b1;
        tick;
        grant_ack = 1'b0;
    endtask

    task automatic test_rotation;
        logic [7:0] exp;
        rst = 1'b1; tick; rst = 1'b0;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp = 8'h01 << (k % 8);
            grant_ack = 1'b0;
            tick;
            vectors++;
            if ({grant, grant_valid} !== {exp, 1'b1}) begin
                miscompares++;
                $display("FAIL rotation[%0d]: got grant=%h valid=%b want %h 1", k, grant, grant_valid, exp);
            end
            grant_ack = 1'b1;
            tick;
            vectors++;
            if ({grant, grant_valid} !== 9'h000) begin
                miscompares++;
                $display("FAIL rotation_gap[%0d]: got grant=%h valid=%b want 00 0", k, grant, grant_valid);
            end
        end
        grant_ack = 1'b0;
    endtask

    task automatic test_wrap_skip;
        rst = 1'b1; tick; rst = 1'b0;
        req = 8'h20; tick;
        grant_ack = 1'b1; tick;
        req = 8'h05; grant_ack = 1'b0; tick;
        vectors++;
        if (grant !== 8'h01) begin
            miscompares++;
            $display("FAIL wrap: got grant=%h want 01", grant);
        end
        grant_ack = 1'b1; tick;
        grant_ack = 1'b0; tick;
        vectors++;
        if (grant !== 8'h04) begin
            miscompares++;
            $display("FAIL skip: got grant=%h want 04", grant);
        end
        grant_ack = 1'b1; tick;
        grant_ack = 1'b0;
    endtask

    task automatic test_hold;
        req = 8'h10; tick;
        req = 8'h00;
        for (int k = 0; k < HOLD; k++) begin
            tick;
            vectors++;
            if ({grant, grant_valid, timeout} !== {8'h10, 2'b10}) begin
                miscompares++;
                $display("FAIL hold[%0d]: got grant=%h valid=%b to=%b want 10 1 0", k, grant, grant_valid, timeout);
            end
        end
        grant_ack = 1'b1; tick;
        vectors++;
        if ({grant, grant_valid, timeout} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL hold_ack: got grant=%h valid=%b to=%b want 00 0 0", grant, grant_valid, timeout);
        end
        grant_ack = 1'b0;
    endtask

    task automatic test_mid_reset;
        req = 8'h04; tick;
        vectors++;
        if (grant !== 8'h04) begin
            miscompares++;
            $display("FAIL mid_reset_setup: got grant=%h want 04", grant);
        end
        rst = 1'b1; tick; rst = 1'b0;
        vectors++;
        if ({grant, grant_valid} !== 9'h000) begin
            miscompares++;
            $display("FAIL mid_reset_drop: got grant=%h valid=%b want 00 0", grant, grant_valid);
        end
        req = 8'h0C; tick;
        vectors++;
        if (grant !== 8'h04) begin
            miscompares++;
            $display("FAIL mid_reset_regrant: got grant=%h want 04", grant);
        end
        rst = 1'b1; tick; rst = 1'b0;
        req = 8'hA4; tick;
        vectors++;
        if (grant !== 8'h04) begin
            miscompares++;
            $display("FAIL reset_ptr: got grant=%h want 04", grant);
        end
        grant_ack = 1'b1; tick;
        grant_ack = 1'b0;
    endtask

    task automatic test_back_to_back;
        rst = 1'b1; tick; rst = 1'b0;
        req = 8'h00; grant_ack = 1'b1; tick;
        req = 8'h01; tick;
        vectors++;
        if (grant !== 8'h01) begin
            miscompares++;
            $display("FAIL ack_in_idle: got grant=%h want 01", grant);
        end
        tick;
        vectors++;
        if ({grant, grant_valid} !== 9'h000) begin
            miscompares++;
            $display("FAIL b2b_gap: got grant=%h valid=%b want 00 0", grant, grant_valid);
        end
        tick;
        vectors++;
        if (grant !== 8'h01) begin
            miscompares++;
            $display("FAIL b2b_regrant: got grant=%h want 01", grant);
        end
        tick;
        grant_ack = 1'b0; req = 8'h00;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        rst = 1'b1; tick; rst = 1'b0;
        req = 8'h03; grant_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick;
            vectors++;
            if ({grant, timeout} !== {8'h01, 1'b0}) begin
                miscompares++;
                $display("FAIL to_hold[%0d]: got grant=%h to=%b want 01 0", k, grant, timeout);
            end
        end
        tick;
        vectors++;
        if ({grant, grant_valid, timeout} !== {8'h00, 2'b01}) begin
            miscompares++;
            $display("FAIL to_release: got grant=%h valid=%b to=%b want 00 0 1", grant, grant_valid, timeout);
        end
        tick;
        vectors++;
        if ({grant, timeout} !== {8'h02, 1'b0}) begin
            miscompares++;
            $display("FAIL to_rotate: got grant=%h to=%b want 02 0", grant, timeout);
        end
        tick; tick; tick;
        grant_ack = 1'b1; tick;
        vectors++;
        if ({grant, grant_valid, timeout} !== {8'h00, 2'b00}) begin
            miscompares++;
            $display("FAIL to_ack_wins: got grant=%h valid=%b to=%b want 00 0 0", grant, grant_valid, timeout);
        end
        grant_ack = 1'b0; req = 8'h00;
    endtask
`else
    task automatic test_no_timeout;
        req = 8'h40; grant_ack = 1'b0; tick;
        req = 8'h00;
        for (int k = 0; k < 40; k++) tick;
        vectors++;
        if ({grant, timeout} !== {8'h40, 1'b0}) begin
            miscompares++;
            $display("FAIL no_timeout: got grant=%h to=%b want 40 0", grant, timeout);
        end
        grant_ack = 1'b1; tick;
        grant_ack = 1'b0;
    endtask
`endif

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; req = 8'h00; grant_ack = 1'b0;
        test_reset;
        test_rotation;
        test_wrap_skip;
        test_hold;
        test_mid_reset;
        test_back_to_back;
`ifdef ARB_TIMEOUT_EN
        test_timeout;
`else
        test_no_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
